gate_vector_sequencer: RTL and testbench

- Self-checking stimulus/response stage for the basic-gate blocks.
- Sits directly upstream of a gate under test and drives its inputs with every combination, 0 to 2^N_IN-1.
- Samples the gate output after a programmable settle time and compares it with the expected truth-table value.
- Reports the mismatch count, the first failing vector, and a pass/done result, replacing hand-written per-gate stimulus lists.

---
 rtl/gate_vector_sequencer_if.sv | 28 ++
 rtl/gate_vector_sequencer.sv | 125 ++++++++++++
 tb/tb_gate_vector_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_vector_sequencer_if.sv
// Stimulus/response bundle between gate_vector_sequencer and its controller.
// The sequencer binds to master; the controller/gate model binds to slave.
interface gate_vector_sequencer_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [2:0]      gate_sel;
    logic [N_IN-1:0] dut_in;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err_vec;
    logic            first_err_valid;

    modport master (
        input  start, gate_sel, dut_y,
        output dut_in, busy, done, pass,
        output err_count, first_err_vec, first_err_valid
    );

    modport slave (
        output start, gate_sel, dut_y,
        input  dut_in, busy, done, pass,
        input  err_count, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Exhaustive truth-table sequencer for a basic gate under test.
// Holds each vector SETTLE cycles, then checks dut_y in one sample cycle.
module gate_vector_sequencer #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gate_vector_sequencer_if.master bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CMAX = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   CONE = CW'(1);
    localparam logic [N_IN-1:0] LAST = '1;
    localparam logic [N_IN-1:0] VONE = N_IN'(1);
    localparam logic [N_IN:0]   EONE = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      sel;
    logic [N_IN-1:0] vec;
    logic [N_IN:0]   errs;
    logic [N_IN-1:0] fvec;
    logic            fvalid;
    logic            pass_q;
    logic            exp_y;
    logic            mism;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:   if (bus.start) nxt = S_SETTLE;
            S_SETTLE: if (cnt == CMAX) nxt = S_SAMPLE;
            S_SAMPLE: nxt = (vec == LAST) ? S_DONE : S_SETTLE;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == S_SETTLE) || (state == S_SAMPLE);
        bus.done = (state == S_DONE);
    end

    // NOT/BUF look only at bit 0; the reductions cover every input.
    always_comb begin
        exp_y = 1'b0;
        unique case (sel)
            3'd0: exp_y = &vec;
            3'd1: exp_y = |vec;
            3'd2: exp_y = ~&vec;
            3'd3: exp_y = ~|vec;
            3'd4: exp_y = ^vec;
            3'd5: exp_y = ~^vec;
            3'd6: exp_y = ~vec[0];
            3'd7: exp_y = vec[0];
            default: exp_y = 1'b0;
        endcase
    end

    assign mism = bus.dut_y ^ exp_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            sel    <= '0;
            vec    <= '0;
            errs   <= '0;
            fvec   <= '0;
            fvalid <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sel    <= bus.gate_sel;
                        vec    <= '0;
                        errs   <= '0;
                        fvec   <= '0;
                        fvalid <= 1'b0;
                        pass_q <= 1'b0;
                        cnt    <= '0;
                    end
                end
                S_SETTLE: cnt <= cnt + CONE;
                S_SAMPLE: begin
                    if (mism) begin
                        errs <= errs + EONE;
                        if (!fvalid) begin
                            fvec   <= vec;
                            fvalid <= 1'b1;
                        end
                    end
                    // Last vector stays on dut_in after the run.
                    if (vec == LAST) begin
                        pass_q <= (errs == '0) && !mism;
                    end else begin
                        vec <= vec + VONE;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dut_in          = vec;
    assign bus.err_count       = errs;
    assign bus.first_err_vec   = fvec;
    assign bus.first_err_valid = fvalid;
    assign bus.pass            = pass_q;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench for gate_vector_sequencer with three parameterisations.
// Gate models sit on dut_y; expectations are hand-computed per edge.
module tb_gate_vector_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode_a = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    gate_vector_sequencer_if #(.N_IN(2)) ia ();
    gate_vector_sequencer_if #(.N_IN(2)) ib ();
    gate_vector_sequencer_if #(.N_IN(3)) ic ();

    // A: AND model, or OR model when mode_a=1. B: XNOR. C: XOR, wrong at 110.
    assign ia.dut_y = mode_a ? |ia.dut_in : &ia.dut_in;
    assign ib.dut_y = ~^ib.dut_in;
    assign ic.dut_y = (^ic.dut_in) ^ (ic.dut_in == 3'b110);

    gate_vector_sequencer #(.N_IN(2), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.master)
    );
    gate_vector_sequencer #(.N_IN(2), .SETTLE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.master)
    );
    gate_vector_sequencer #(.N_IN(3), .SETTLE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(ic.master)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, ".dut_in"}, 32'(ia.dut_in), 0);
        chk({tag, ".busy"}, 32'(ia.busy), 0);
        chk({tag, ".done"}, 32'(ia.done), 0);
        chk({tag, ".pass"}, 32'(ia.pass), 0);
        chk({tag, ".err"}, 32'(ia.err_count), 0);
        chk({tag, ".fvec"}, 32'(ia.first_err_vec), 0);
        chk({tag, ".fvalid"}, 32'(ia.first_err_valid), 0);
    endtask

    initial begin
        ia.start = 0; ia.gate_sel = 0;
        ib.start = 0; ib.gate_sel = 0;
        ic.start = 0; ic.gate_sel = 0;

        // Reset state
        rst_n = 0;
        tick(2);
        rst_n = 1;
        chk_a_zero("rst");
        chk("rst.b.dut_in", 32'(ib.dut_in), 0);
        chk("rst.c.busy", 32'(ic.busy), 0);

        // Correct AND model; gate_sel change after accept ignored
        mode_a = 0;
        ia.gate_sel = 3'd0;
        ia.start = 1;
        tick(1);
        ia.start = 0;
        ia.gate_sel = 3'd1;
        chk("and.e0.busy", 32'(ia.busy), 1);
        chk("and.e0.in", 32'(ia.dut_in), 0);
        tick(1);
        chk("and.e1.in", 32'(ia.dut_in), 0);
        tick(1);
        chk("and.e2.in", 32'(ia.dut_in), 1);
        tick(2);
        chk("and.e4.in", 32'(ia.dut_in), 2);
        tick(2);
        chk("and.e6.in", 32'(ia.dut_in), 3);
        tick(1);
        chk("and.e7.busy", 32'(ia.busy), 1);
        chk("and.e7.done", 32'(ia.done), 0);
        tick(1);
        chk("and.e8.done", 32'(ia.done), 1);
        chk("and.e8.busy", 32'(ia.busy), 0);
        chk("and.e8.pass", 32'(ia.pass), 1);
        chk("and.e8.err", 32'(ia.err_count), 0);
        chk("and.e8.fvalid", 32'(ia.first_err_valid), 0);
        tick(1);
        chk("and.e9.done", 32'(ia.done), 0);
        chk("and.e9.in", 32'(ia.dut_in), 3);
        chk("and.e9.pass", 32'(ia.pass), 1);

        // OR model while AND expected
        mode_a = 1;
        ia.gate_sel = 3'd0;
        ia.start = 1;
        tick(1);
        ia.start = 0;
        chk("or.e0.pass", 32'(ia.pass), 0);
        tick(4);
        chk("or.e4.err", 32'(ia.err_count), 1);
        chk("or.e4.fvec", 32'(ia.first_err_vec), 1);
        chk("or.e4.fvalid", 32'(ia.first_err_valid), 1);
        tick(4);
        chk("or.e8.done", 32'(ia.done), 1);
        chk("or.e8.err", 32'(ia.err_count), 2);
        chk("or.e8.fvec", 32'(ia.first_err_vec), 1);
        chk("or.e8.fvalid", 32'(ia.first_err_valid), 1);
        chk("or.e8.pass", 32'(ia.pass), 0);
        tick(2);
        chk("or.hold.err", 32'(ia.err_count), 2);

        // start re-asserted mid-run and in the done cycle
        mode_a = 0;
        ia.start = 1;
        tick(1);
        ia.start = 0;
        tick(2);
        ia.start = 1;
        tick(1);
        ia.start = 0;
        chk("rs.e3.in", 32'(ia.dut_in), 1);
        tick(1);
        chk("rs.e4.in", 32'(ia.dut_in), 2);
        ia.start = 1;
        tick(1);
        ia.start = 0;
        chk("rs.e5.in", 32'(ia.dut_in), 2);
        chk("rs.e5.busy", 32'(ia.busy), 1);
        tick(1);
        chk("rs.e6.in", 32'(ia.dut_in), 3);
        tick(2);
        chk("rs.e8.done", 32'(ia.done), 1);
        chk("rs.e8.pass", 32'(ia.pass), 1);
        ia.start = 1;
        tick(1);
        ia.start = 0;
        chk("rs.e9.busy", 32'(ia.busy), 0);
        chk("rs.e9.done", 32'(ia.done), 0);
        chk("rs.e9.in", 32'(ia.dut_in), 3);
        tick(1);
        chk("rs.e10.busy", 32'(ia.busy), 0);

        // Reset at edge 5 mid-run, then a fresh run
        ia.start = 1;
        tick(1);
        ia.start = 0;
        tick(4);
        chk("mr.e4.in", 32'(ia.dut_in), 2);
        rst_n = 0;
        tick(1);
        rst_n = 1;
        chk_a_zero("mr.e5");
        tick(2);
        chk("mr.after.done", 32'(ia.done), 0);
        chk("mr.after.busy", 32'(ia.busy), 0);
        ia.start = 1;
        tick(1);
        ia.start = 0;
        tick(8);
        chk("mr.run.done", 32'(ia.done), 1);
        chk("mr.run.pass", 32'(ia.pass), 1);
        chk("mr.run.err", 32'(ia.err_count), 0);

        // SETTLE=3, XNOR
        ib.gate_sel = 3'd5;
        ib.start = 1;
        tick(1);
        ib.start = 0;
        tick(3);
        chk("xn.e3.in", 32'(ib.dut_in), 0);
        chk("xn.e3.busy", 32'(ib.busy), 1);
        tick(1);
        chk("xn.e4.in", 32'(ib.dut_in), 1);
        tick(4);
        chk("xn.e8.in", 32'(ib.dut_in), 2);
        tick(7);
        chk("xn.e15.in", 32'(ib.dut_in), 3);
        chk("xn.e15.done", 32'(ib.done), 0);
        tick(1);
        chk("xn.e16.done", 32'(ib.done), 1);
        chk("xn.e16.pass", 32'(ib.pass), 1);
        chk("xn.e16.err", 32'(ib.err_count), 0);

        // N_IN=3 XOR with a single bad vector at 110
        ic.gate_sel = 3'd4;
        ic.start = 1;
        tick(1);
        ic.start = 0;
        tick(12);
        chk("x3.e12.err", 32'(ic.err_count), 0);
        chk("x3.e12.in", 32'(ic.dut_in), 6);
        tick(2);
        chk("x3.e14.err", 32'(ic.err_count), 1);
        chk("x3.e14.fvec", 32'(ic.first_err_vec), 6);
        tick(1);
        chk("x3.e15.done", 32'(ic.done), 0);
        tick(1);
        chk("x3.e16.done", 32'(ic.done), 1);
        chk("x3.e16.err", 32'(ic.err_count), 1);
        chk("x3.e16.fvec", 32'(ic.first_err_vec), 6);
        chk("x3.e16.fvalid", 32'(ic.first_err_valid), 1);
        chk("x3.e16.pass", 32'(ic.pass), 0);
        chk("x3.e16.in", 32'(ic.dut_in), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
